// File: rtl/press_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : press_event_decoder
// Purpose  : Classifies a debounced switch level into short, long and
//            double-click pulses and keeps a wrapping event count.
// Revision : 1.0 - initial release
// ============================================================================
module press_event_decoder #(
  parameter int LONG_LIMIT    = 12500000,
  parameter int DCLICK_WINDOW = 6250000,
  parameter int TIMER_W       = 24,
  parameter int COUNT_W       = 8
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_switch,
  output logic               o_short,
  output logic               o_long,
  output logic               o_double,
  output logic               o_held,
  output logic [COUNT_W-1:0] o_count
);

  localparam logic [TIMER_W-1:0] c_LONG_LAST   = TIMER_W'(LONG_LIMIT - 1);
  localparam logic [TIMER_W-1:0] c_DCLICK_LAST = TIMER_W'(DCLICK_WINDOW - 1);
  localparam logic [TIMER_W-1:0] c_TIMER_ONE   = TIMER_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS1    = 3'd1,
    S_WAIT2     = 3'd2,
    S_PRESS2    = 3'd3,
    S_LONG_HELD = 3'd4
  } state_t;

  state_t               r_state;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_prev;
  logic                 r_short;
  logic                 r_long;
  logic                 r_double;
  logic                 r_held;
  logic [COUNT_W-1:0]   r_count;
  logic                 w_rise;

  assign w_rise = i_switch & ~r_prev;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_prev   <= 1'b0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_held   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_prev   <= i_switch;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_held   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_PRESS1;
            r_timer <= c_TIMER_ONE;
          end
        end
        S_PRESS1: begin
          if (!i_switch) begin
            r_state <= S_WAIT2;
            r_timer <= c_TIMER_ONE;
          end else if (r_timer == c_LONG_LAST) begin
            r_state <= S_LONG_HELD;
            r_long  <= 1'b1;
            r_held  <= 1'b1;
            r_count <= r_count + 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WAIT2: begin
          if (i_switch) begin
            r_state <= S_PRESS2;
            r_timer <= c_TIMER_ONE;
          end else if (r_timer == c_DCLICK_LAST) begin
            r_state <= S_IDLE;
            r_short <= 1'b1;
            r_count <= r_count + 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_PRESS2: begin
          if (!i_switch) begin
            r_state  <= S_IDLE;
            r_double <= 1'b1;
            r_count  <= r_count + 1'b1;
          end else if (r_timer == c_LONG_LAST) begin
            // First press resolves as short; the held second press is long.
            r_state <= S_LONG_HELD;
            r_short <= 1'b1;
            r_long  <= 1'b1;
            r_held  <= 1'b1;
            r_count <= r_count + 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_LONG_HELD: begin
          if (!i_switch) begin
            r_state <= S_IDLE;
          end else begin
            r_held <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign o_short  = r_short;
  assign o_long   = r_long;
  assign o_double = r_double;
  assign o_held   = r_held;
  assign o_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_press_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_press_event_decoder
// Purpose  : Directed scoreboard bench for press_event_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_press_event_decoder;

  localparam int c_LONG   = 8;
  localparam int c_WINDOW = 5;
  localparam int c_TW     = 4;
  localparam int c_CW     = 3;

  logic            i_Clk;
  logic            i_Rst;
  logic            i_switch;
  logic            o_short;
  logic            o_long;
  logic            o_double;
  logic            o_held;
  logic [c_CW-1:0] o_count;

  typedef struct {
    logic [6:0] v;
    string      tag;
  } exp_t;

  exp_t            r_sb[$];
  logic [c_CW-1:0] r_exp_count;
  int              r_checks;
  int              r_failures;

  press_event_decoder #(
    .LONG_LIMIT    (c_LONG),
    .DCLICK_WINDOW (c_WINDOW),
    .TIMER_W       (c_TW),
    .COUNT_W       (c_CW)
  ) u_dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_switch (i_switch),
    .o_short  (o_short),
    .o_long   (o_long),
    .o_double (o_double),
    .o_held   (o_held),
    .o_count  (o_count)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  function automatic logic [6:0] observed();
    return {o_short, o_long, o_double, o_held, o_count};
  endfunction

  task automatic check_now(input logic [6:0] exp_v, input string tag);
    logic [6:0] obs;
    obs = observed();
    r_checks++;
    assert (obs === exp_v) else begin
      r_failures++;
      $error("FAIL %s: observed s/l/d/h/cnt=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Drive one sample, queue the outputs expected after the edge, then compare.
  task automatic step(input logic sw, input logic es, input logic el,
                      input logic ed, input logic eh, input string tag);
    exp_t e;
    exp_t got;
    i_switch = sw;
    if (es | el | ed) r_exp_count = r_exp_count + 1'b1;
    e.v   = {es, el, ed, eh, r_exp_count};
    e.tag = tag;
    r_sb.push_back(e);
    @(posedge i_Clk);
    #1;
    got = r_sb.pop_front();
    check_now(got.v, got.tag);
  endtask

  task automatic quiet(input logic sw, input int n, input string tag);
    for (int i = 0; i < n; i++) step(sw, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic short_press(input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    quiet(1'b0, c_WINDOW - 1, tag);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    r_checks    = 0;
    r_failures  = 0;
    r_exp_count = '0;
    i_switch    = 1'b0;
    i_Rst       = 1'b1;

    // Reset state
    @(posedge i_Clk);
    #1;
    check_now(7'b0, "reset");
    @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    quiet(1'b0, 2, "idle_after_reset");

    // Short press: 3 high, short on the 5th low
    quiet(1'b1, 3, "short_hi");
    quiet(1'b0, c_WINDOW - 1, "short_lo");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "short_pulse");
    quiet(1'b0, 2, "short_after");

    // Reset mid-PRESS1 aborts the press and clears the count
    quiet(1'b1, 2, "abort_hi");
    i_Rst = 1'b1;
    #1;
    check_now(7'b0, "abort_async_reset");
    i_switch = 1'b0;
    @(posedge i_Clk);
    #1;
    check_now(7'b0, "abort_reset_held");
    i_Rst       = 1'b0;
    r_exp_count = '0;
    quiet(1'b0, c_WINDOW + 3, "abort_no_pulse");

    // Long press: 12 high, long on the 8th, held until the first low
    quiet(1'b1, c_LONG - 1, "long_hi");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "long_pulse");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "long_held");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "long_release");
    quiet(1'b0, c_WINDOW + 1, "long_after");

    // Double click: 2 high, 3 low, 2 high, then low
    quiet(1'b1, 2, "dbl_hi1");
    quiet(1'b0, 3, "dbl_lo1");
    quiet(1'b1, 2, "dbl_hi2");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "dbl_pulse");
    quiet(1'b0, c_WINDOW + 1, "dbl_after");

    // Late second press: two separate short presses
    quiet(1'b1, 2, "late_hi1");
    quiet(1'b0, c_WINDOW - 1, "late_lo1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "late_short1");
    quiet(1'b1, 2, "late_hi2");
    quiet(1'b0, c_WINDOW - 1, "late_lo2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "late_short2");
    quiet(1'b0, 2, "late_after");

    // Second press held: short and long together
    quiet(1'b1, 2, "held2_hi1");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "held2_lo");
    quiet(1'b1, c_LONG - 1, "held2_hi2");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "held2_short_long");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "held2_held");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "held2_release");

    // Eight 1-sample presses: counter wraps past all-ones
    for (int i = 0; i < 8; i++) short_press("wrap_short");
    quiet(1'b0, 3, "final_idle");

    if (r_sb.size() != 0) begin
      r_failures++;
      $error("FAIL scoreboard_drain: observed %0d pending entries, expected 0", r_sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
